// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: assembles UART command frames, hands them to the accelerator,
// and sequences the 3-byte ACK/NAK response through uart_tx.
module uart_cmd_ctrl #(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 1_000_000,
    localparam int AW         = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_busy,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [7:0]    cmd_op,
    output logic [7:0]    cmd_len,
    input  logic [AW-1:0] cmd_rd_addr,
    output logic [7:0]    cmd_rd_data,
    input  logic          rsp_valid,
    output logic          rsp_ready,
    input  logic [7:0]    rsp_status,
    output logic [7:0]    drop_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] S_SYNC = 3'd0;
    localparam logic [2:0] S_OP   = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_PAY  = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_CMD  = 3'd5;
    localparam logic [2:0] S_RSP  = 3'd6;
    localparam logic [2:0] S_TX   = 3'd7;

    localparam logic [1:0] T_GO = 2'd0;
    localparam logic [1:0] T_HI = 2'd1;
    localparam logic [1:0] T_LO = 2'd2;

    logic [2:0]    state;
    logic [1:0]    tph, tidx;
    logic [7:0]    op_r, len_r, chk, cnt, b1, b2;
    logic [TW-1:0] tcnt;
    logic [7:0]    pbuf [MAX_LEN];
    logic          in_frame, busy_st, timeout;

    assign in_frame = state inside {S_OP, S_LEN, S_PAY, S_CHK};
    assign busy_st  = state inside {S_CMD, S_RSP, S_TX};
    assign timeout  = in_frame && !rx_valid && tcnt == TW'(TIMEOUT_CYC - 1);

    assign cmd_valid   = state == S_CMD;
    assign rsp_ready   = state == S_RSP;
    assign cmd_op      = op_r;
    assign cmd_len     = len_r;
    assign cmd_rd_data = pbuf[cmd_rd_addr];
    assign tx_start    = state == S_TX && tph == T_GO && !tx_busy;
    // tidx only advances after tx_busy falls, so the byte holds for the whole send
    assign tx_data     = state != S_TX ? 8'h00 : tidx == 2'd0 ? 8'h5A : tidx == 2'd1 ? b1 : b2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_SYNC;
            tph      <= T_GO;
            tidx     <= 2'd0;
            op_r     <= 8'h00;
            len_r    <= 8'h00;
            chk      <= 8'h00;
            cnt      <= 8'h00;
            b1       <= 8'h00;
            b2       <= 8'h00;
            tcnt     <= '0;
            drop_cnt <= 8'h00;
        end else begin
            tcnt <= (rx_valid || !in_frame) ? '0 : tcnt + 1'b1;
            if (rx_valid && busy_st && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
            if (timeout) begin
                b1    <= 8'hFF;
                b2    <= 8'h03;
                state <= S_TX;
            end else begin
                case (state)
                    S_SYNC: if (rx_valid && rx_data == 8'hA5) state <= S_OP;
                    S_OP: if (rx_valid) begin
                        op_r  <= rx_data;
                        chk   <= rx_data;
                        state <= S_LEN;
                    end
                    S_LEN: if (rx_valid) begin
                        len_r <= rx_data;
                        chk   <= chk ^ rx_data;
                        cnt   <= 8'h00;
                        if ({1'b0, rx_data} > 9'(MAX_LEN)) begin
                            b1    <= 8'hFF;
                            b2    <= 8'h02;
                            state <= S_TX;
                        end else begin
                            state <= rx_data == 8'h00 ? S_CHK : S_PAY;
                        end
                    end
                    S_PAY: if (rx_valid) begin
                        chk <= chk ^ rx_data;
                        cnt <= cnt + 8'd1;
                        if (cnt + 8'd1 == len_r) state <= S_CHK;
                    end
                    S_CHK: if (rx_valid) begin
                        if (rx_data == chk) begin
                            state <= S_CMD;
                        end else begin
                            b1    <= 8'hFF;
                            b2    <= 8'h01;
                            state <= S_TX;
                        end
                    end
                    S_CMD: if (cmd_ready) state <= S_RSP;
                    S_RSP: if (rsp_valid) begin
                        b1    <= op_r;
                        b2    <= rsp_status;
                        state <= S_TX;
                    end
                    S_TX: begin
                        case (tph)
                            T_GO: if (!tx_busy) tph <= T_HI;
                            T_HI: if (tx_busy) tph <= T_LO;
                            default: if (!tx_busy) begin
                                tph  <= T_GO;
                                tidx <= tidx == 2'd2 ? 2'd0 : tidx + 2'd1;
                                if (tidx == 2'd2) state <= S_SYNC;
                            end
                        endcase
                    end
                    default: state <= S_SYNC;
                endcase
            end
        end
    end

    // payload storage is don't-care after reset, so it carries no reset
    always_ff @(posedge clk) begin
        if (state == S_PAY && rx_valid)
            pbuf[cnt[AW-1:0]] <= rx_data;
    end
endmodule
